// File: rtl/ifstmt_accum.sv
// ifstmt_accum: sums groups of COUNT samples with wrap or saturating add, result held on a valid/ready output
module ifstmt_accum #(
    parameter int WIDTH    = 32,
    parameter int COUNT    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH:0]   sum;
    logic [7:0]       cnt;
    logic             ovf;
    assign sum = {1'b0, acc} + {1'b0, in_data};
    generate
        if (SATURATE != 0) begin : g_sat
            assign nxt = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end else begin : g_wrap
            assign nxt = sum[WIDTH-1:0];
        end
    endgenerate
    // handshake flags come from the state register only; reset just masks acceptance
    assign in_ready     = !reset && state != HOLD;
    assign out_valid    = state == HOLD;
    assign out_data     = acc;
    assign out_overflow = ovf;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    acc   <= in_data;
                    cnt   <= 8'd1;
                    ovf   <= 1'b0;
                    state <= COUNT == 1 ? HOLD : ACCUM;
                end
                ACCUM: if (in_valid) begin
                    acc <= nxt;
                    ovf <= ovf | sum[WIDTH];
                    cnt <= cnt + 8'd1;
                    if (cnt + 8'd1 == 8'(COUNT)) state <= HOLD;
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifstmt_accum.sv
// tb_ifstmt_accum: directed checks of wrap, saturate and COUNT=1 instances against a group-sum model
module tb_ifstmt_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [31:0] din[3];
    logic [31:0] dout[3];
    logic        iv[3];
    logic        ir[3];
    logic        ov[3];
    logic        ordy[3];
    logic        of[3];
    int checks = 0;
    int errors = 0;
    ifstmt_accum #(.WIDTH(32), .COUNT(4), .SATURATE(0)) u0 (
        .clock(clk), .reset(rst), .in_data(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_data(dout[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_overflow(of[0]));
    ifstmt_accum #(.WIDTH(32), .COUNT(4), .SATURATE(1)) u1 (
        .clock(clk), .reset(rst), .in_data(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_data(dout[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_overflow(of[1]));
    ifstmt_accum #(.WIDTH(32), .COUNT(1), .SATURATE(0)) u2 (
        .clock(clk), .reset(rst), .in_data(din[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_data(dout[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_overflow(of[2]));

    // model: exact group total in 64 bits; any carry in the group <=> total exceeds 32 bits
    logic [63:0] tot[3];
    int          n[3];
    bit          pend[3];
    bit          started = 1'b0;
    function automatic int cnt_of(int i);
        return i == 2 ? 1 : 4;
    endfunction
    function automatic logic [31:0] exp_data(int i);
        logic [63:0] t = tot[i];
        if (i == 1 && t > 64'hFFFF_FFFF) return '1;
        return t[31:0];
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            started <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                pend[i] <= 1'b0;
                n[i]    <= 0;
                tot[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    if (ordy[i]) pend[i] <= 1'b0;
                end else if (iv[i]) begin
                    tot[i] <= n[i] == 0 ? 64'(din[i]) : tot[i] + 64'(din[i]);
                    if (n[i] + 1 == cnt_of(i)) begin
                        n[i]    <= 0;
                        pend[i] <= 1'b1;
                    end else n[i] <= n[i] + 1;
                end
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d in_ready", i), 64'(ir[i]), 64'(!rst && !pend[i]));
                chk($sformatf("u%0d out_valid", i), 64'(ov[i]), 64'(pend[i]));
                if (pend[i]) begin
                    chk($sformatf("u%0d out_data", i), 64'(dout[i]), 64'(exp_data(i)));
                    chk($sformatf("u%0d out_overflow", i), 64'(of[i]), 64'(tot[i] > 64'hFFFF_FFFF));
                end
            end
        end
    end

    task automatic send(int i, logic [31:0] v);
        din[i] = v;
        iv[i]  = 1'b1;
        @(posedge clk);
        #1;
    endtask
    // one HOLD cycle with the literal result, then back to ready
    task automatic expect_out(int i, logic [31:0] d, logic o, string nm);
        iv[i] = 1'b0;
        @(negedge clk);
        chk({nm, " valid"}, 64'(ov[i]), 64'd1);
        chk({nm, " data"}, 64'(dout[i]), 64'(d));
        chk({nm, " ovf"}, 64'(of[i]), 64'(o));
        chk({nm, " busy"}, 64'(ir[i]), 64'd0);
        @(negedge clk);
        chk({nm, " valid drop"}, 64'(ov[i]), 64'd0);
        chk({nm, " ready back"}, 64'(ir[i]), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i]  = '0;
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset out_data", 64'(dout[i]), 64'd0);
            chk("reset out_valid", 64'(ov[i]), 64'd0);
            chk("reset out_overflow", 64'(of[i]), 64'd0);
            chk("reset in_ready", 64'(ir[i]), 64'd1);
        end
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        expect_out(0, 32'd10, 1'b0, "wrap sum");
        send(0, 32'hFFFF_FFFF); send(0, 2); send(0, 0); send(0, 0);
        expect_out(0, 32'd1, 1'b1, "wrap ovf");
        send(1, 1); send(1, 2); send(1, 3); send(1, 4);
        expect_out(1, 32'd10, 1'b0, "sat small");
        send(1, 32'hFFFF_FFF0); send(1, 32'h20); send(1, 0); send(1, 5);
        expect_out(1, 32'hFFFF_FFFF, 1'b1, "sat clamp");
        ordy[0] = 1'b0;
        send(0, 7); send(0, 8); send(0, 9); send(0, 10);
        iv[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp valid", 64'(ov[0]), 64'd1);
            chk("bp data", 64'(dout[0]), 64'd34);
            chk("bp ovf", 64'(of[0]), 64'd0);
            chk("bp in_ready", 64'(ir[0]), 64'd0);
        end
        din[0]  = 32'd100;
        iv[0]   = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp released", 64'(ov[0]), 64'd0);
        chk("bp ready", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1;
        send(0, 0); send(0, 0); send(0, 0);
        expect_out(0, 32'd100, 1'b0, "bp next group");
        send(2, 32'd11);
        chk("c1 data a", 64'(dout[2]), 64'd11);
        iv[2] = 1'b0;
        @(posedge clk);
        #1;
        chk("c1 gap", 64'(ov[2]), 64'd0);
        send(2, 32'd22);
        expect_out(2, 32'd22, 1'b0, "c1 b");
        send(0, 50); send(0, 60);
        iv[0] = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst mid valid", 64'(ov[0]), 64'd0);
        chk("rst mid ready", 64'(ir[0]), 64'd1);
        send(0, 5); send(0, 5); send(0, 5); send(0, 5);
        expect_out(0, 32'd20, 1'b0, "post reset");
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifstmt_accum.md
# ifstmt_accum

Downstream consumer of the combinational `a` result stage. Accepts a stream of WIDTH-bit samples over a valid/ready handshake and sums each group of COUNT samples. Presents each sum on a registered valid/ready output. A parameter-driven generate-if selects wrapping or saturating addition. The block exercises constant-condition and generate-if elaboration on real sequential logic.

## Interface
Parameters:
- `WIDTH`, 32: sample and sum width in bits (≥ 2).
- `COUNT`, 4: samples per group (1..255).
- `SATURATE`, 0: generate-if select. 0 = wrapping add; 1 = saturating add (clamps to all-ones).

Ports:
- `clock`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `in_data`  input  WIDTH: sample value, unsigned.
- `in_valid`  input  1: sample present.
- `in_ready`  output  1: block can accept a sample.
- `out_data`  output  WIDTH: group sum.
- `out_valid`  output  1: `out_data` / `out_overflow` hold a complete group result.
- `out_ready`  input  1: consumer accepts the result.
- `out_overflow`  output  1: a carry out of bit WIDTH-1 occurred in this group.

## Operation
- Accept: an input transfer occurs when `in_valid && in_ready` at a rising edge. An output transfer occurs when `out_valid && out_ready`.
- State machine has three states: IDLE, ACCUM, HOLD.
- IDLE: `in_ready`=1.
  - On accept: acc ← `in_data`, cnt ← 1, ovf ← 0.
  - Next state is HOLD if COUNT==1, else ACCUM.
- ACCUM: `in_ready`=1.
  - On accept: compute the (WIDTH+1)-bit sum = acc + `in_data`.
  - SATURATE=0: acc ← sum[WIDTH-1:0].
  - SATURATE=1: acc ← all-ones if sum[WIDTH], else sum[WIDTH-1:0].
  - ovf ← ovf | sum[WIDTH] in both modes.
  - cnt ← cnt+1. Go to HOLD when cnt+1 == COUNT.
  - No accept: hold all state.
- HOLD: `in_ready`=0, `out_valid`=1. `out_data`=acc and `out_overflow`=ovf stay stable until the output transfer.
  - On output transfer: go to IDLE.
  - A new sample cannot be accepted in the same cycle as the output transfer.
- Once in SATURATE=1, acc stays at all-ones for the rest of the group.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready` to them.
- cnt is 8 bits wide and never wraps, because COUNT ≤ 255.

## Timing
- Reset values (the cycle after `reset` is sampled high): state=IDLE, acc=0, cnt=0, ovf=0, `out_data`=0, `out_valid`=0, `out_overflow`=0, `in_ready`=1.
- `in_ready` is 0 while `reset` is high.
- Reset mid-group or in HOLD discards the partial or pending result. No output transfer is reported.
- Latency: the last sample of a group accepted at edge N gives `out_valid`=1 after edge N.
- Minimum period: COUNT+1 cycles per group (COUNT accepts plus 1 HOLD cycle with `out_ready`=1).
- Backpressure: `out_ready`=0 holds HOLD indefinitely with outputs stable. `in_valid` is ignored during HOLD.
- A gap in `in_valid` during ACCUM stalls the count. Partial groups never time out.

## Test plan
- Wrap, default params: feed 1,2,3,4 back-to-back with `out_ready`=1 -> `out_valid` for exactly 1 cycle, after the 4th accept edge, with `out_data`=10 and `out_overflow`=0. `in_ready`=0 in that cycle, then back to 1.
- Wrap overflow, SATURATE=0: feed 0xFFFFFFFF,2,0,0 -> `out_data`=0x00000001, `out_overflow`=1.
- Saturate, SATURATE=1: feed 0xFFFFFFF0,0x20,0,5 -> `out_data`=0xFFFFFFFF, `out_overflow`=1.
- Backpressure: complete a group with `out_ready`=0 for 5 cycles -> `out_valid`, `out_data`, `out_overflow` constant and `in_ready`=0 throughout. Raising `out_ready` gives one transfer, and the next sample is accepted one cycle later.
- COUNT=1 with `in_valid` toggling 1,0,1: `out_data` equals each sample, each followed by one HOLD cycle.
- Reset after 2 of 4 samples: `out_valid` stays 0. A following group 5,5,5,5 yields `out_data`=20 with no contribution from pre-reset samples.
